ib_bm_requester: RTL and testbench

IB_BM_REQUESTER -- requirements
Module: ib_bm_requester

---
 rtl/ib_bm_requester.sv | 218 +++++++++++++++++++++
 tb/tb_ib_bm_requester.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ib_bm_requester.sv
// ib_bm_requester: splits a DMA descriptor into bus-master requests that
// never exceed MAX_CHUNK bytes, never cross a 4 KB global boundary, and
// never leave more than MAX_OUTST acknowledged-but-uncompleted operations.
// Each accepted request is followed by a one-cycle gap on BM_REQ while the
// next chunk is registered.
module ib_bm_requester #(
    parameter int MAX_CHUNK = 512,
    parameter int MAX_OUTST = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [63:0] i_desc_gaddr,
    input  logic [31:0] i_desc_laddr,
    input  logic [15:0] i_desc_len,
    input  logic        i_desc_dir,
    input  logic        i_desc_vld,
    output logic        o_desc_rdy,
    output logic [63:0] o_bm_global_addr,
    output logic [31:0] o_bm_local_addr,
    output logic [11:0] o_bm_length,
    output logic [15:0] o_bm_tag,
    output logic [1:0]  o_bm_trans_type,
    output logic        o_bm_req,
    input  logic        i_bm_ack,
    input  logic [15:0] i_bm_op_tag,
    input  logic        i_bm_op_done,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    localparam logic [16:0] C_MAX_CHUNK = 17'(MAX_CHUNK);
    localparam logic [3:0]  C_MAX_OUTST = 4'(MAX_OUTST);

    // Chunk size = min(remaining, MAX_CHUNK, bytes left in the current 4 KB page).
    function automatic logic [12:0] f_chunk(input logic [16:0] rem, input logic [11:0] goff);
        logic [16:0] to_bound;
        logic [16:0] m;
        to_bound = 17'd4096 - {5'd0, goff};
        m = rem;
        if (C_MAX_CHUNK < m) begin
            m = C_MAX_CHUNK;
        end else begin
            m = m;
        end
        if (to_bound < m) begin
            m = to_bound;
        end else begin
            m = m;
        end
        return m[12:0];
    endfunction

    state_t      r_state;
    state_t      w_state_next;
    logic [63:0] r_gaddr;
    logic [31:0] r_laddr;
    logic [16:0] r_rem;
    logic [12:0] r_chunk;
    logic        r_dir;
    logic [7:0]  r_tag;
    logic [3:0]  r_outst;
    logic        r_req;
    logic        r_rdy;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic        w_accept;
    logic        w_ack;
    logic [3:0]  w_outst_next;
    logic        w_err_evt;
    logic [16:0] w_rem_after;
    logic [63:0] w_gaddr_after;
    logic [31:0] w_laddr_after;
    logic        w_unused;

    // The completion tag is informational only; it does not steer any logic.
    assign w_unused      = ^i_bm_op_tag;

    assign w_accept      = (r_state == ST_IDLE) & r_rdy & i_desc_vld;
    assign w_ack         = r_req & i_bm_ack;
    assign w_rem_after   = r_rem - {4'd0, r_chunk};
    assign w_gaddr_after = r_gaddr + {51'd0, r_chunk};
    assign w_laddr_after = r_laddr + {19'd0, r_chunk};

    assign o_desc_rdy       = r_rdy;
    assign o_bm_global_addr = r_gaddr;
    assign o_bm_local_addr  = r_laddr;
    assign o_bm_length      = r_chunk[11:0];
    assign o_bm_tag         = {8'h00, r_tag};
    assign o_bm_trans_type  = {1'b0, r_dir};
    assign o_bm_req         = r_req;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_err            = r_err;

    // Outstanding counter update; a completion with nothing outstanding is an error.
    always_comb begin
        w_outst_next = r_outst;
        w_err_evt    = 1'b0;
        case ({w_ack, i_bm_op_done})
            2'b10: w_outst_next = r_outst + 4'd1;
            2'b01: begin
                if (r_outst == 4'd0) begin
                    w_err_evt = 1'b1;
                end else begin
                    w_outst_next = r_outst - 4'd1;
                end
            end
            default: w_outst_next = r_outst;
        endcase
    end

    // Next-state logic for the descriptor FSM.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && (i_desc_len != 16'd0)) begin
                    w_state_next = ST_ISSUE;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (w_ack && (w_rem_after == 17'd0)) begin
                    w_state_next = ST_WAIT_DONE;
                end else begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_WAIT_DONE: begin
                if (r_outst == 4'd0) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_WAIT_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Descriptor datapath, request fields and registered status outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gaddr <= 64'd0;
            r_laddr <= 32'd0;
            r_rem   <= 17'd0;
            r_chunk <= 13'd0;
            r_dir   <= 1'b0;
            r_tag   <= 8'd0;
            r_outst <= 4'd0;
            r_req   <= 1'b0;
            r_rdy   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_outst <= w_outst_next;
            r_err   <= r_err | w_err_evt;
            r_busy  <= (w_state_next != ST_IDLE);
            // Ready only after a full cycle spent in IDLE, so it trails DONE by one cycle.
            r_rdy   <= (r_state == ST_IDLE) & ~w_accept;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_gaddr <= i_desc_gaddr;
                        r_laddr <= i_desc_laddr;
                        r_rem   <= {1'b0, i_desc_len};
                        r_dir   <= i_desc_dir;
                        r_chunk <= f_chunk({1'b0, i_desc_len}, i_desc_gaddr[11:0]);
                        r_req   <= (i_desc_len != 16'd0) && (w_outst_next < C_MAX_OUTST);
                        r_done  <= (i_desc_len == 16'd0);
                    end else begin
                        r_req   <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (w_ack) begin
                        r_gaddr <= w_gaddr_after;
                        r_laddr <= w_laddr_after;
                        r_rem   <= w_rem_after;
                        r_tag   <= r_tag + 8'd1;
                        r_chunk <= f_chunk(w_rem_after, w_gaddr_after[11:0]);
                        r_req   <= 1'b0;
                    end else begin
                        r_req   <= (w_outst_next < C_MAX_OUTST);
                    end
                end
                ST_WAIT_DONE: begin
                    r_req  <= 1'b0;
                    r_done <= (r_outst == 4'd0);
                end
                default: begin
                    r_req  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ib_bm_requester.sv
// Directed self-checking bench for ib_bm_requester.
module tb_ib_bm_requester;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // Main instance: MAX_CHUNK 512, MAX_OUTST 2.
    logic [63:0] gaddr = 64'd0;
    logic [31:0] laddr = 32'd0;
    logic [15:0] len = 16'd0;
    logic        dir = 1'b0, vld = 1'b0, ack = 1'b0, op_done = 1'b0;
    logic        rdy, req, busy, done, err;
    logic [63:0] bm_g;
    logic [31:0] bm_l;
    logic [11:0] bm_len;
    logic [15:0] bm_tag;
    logic [1:0]  bm_type;

    // Second instance: MAX_CHUNK 4096, MAX_OUTST 15.
    logic [63:0] k_gaddr = 64'd0;
    logic [15:0] k_len = 16'd0;
    logic        k_vld = 1'b0, k_ack = 1'b0, k_op_done = 1'b0;
    logic        k_rdy, k_req, k_busy, k_done, k_err;
    logic [63:0] k_bm_g;
    logic [31:0] k_bm_l;
    logic [11:0] k_bm_len;
    logic [15:0] k_bm_tag;
    logic [1:0]  k_bm_type;

    int n_cmp = 0;
    int n_mis = 0;

    ib_bm_requester #(.MAX_CHUNK(512), .MAX_OUTST(2)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_desc_gaddr(gaddr), .i_desc_laddr(laddr), .i_desc_len(len),
        .i_desc_dir(dir), .i_desc_vld(vld), .o_desc_rdy(rdy),
        .o_bm_global_addr(bm_g), .o_bm_local_addr(bm_l), .o_bm_length(bm_len),
        .o_bm_tag(bm_tag), .o_bm_trans_type(bm_type), .o_bm_req(req),
        .i_bm_ack(ack), .i_bm_op_tag(16'h0000), .i_bm_op_done(op_done),
        .o_busy(busy), .o_done(done), .o_err(err)
    );

    ib_bm_requester #(.MAX_CHUNK(4096), .MAX_OUTST(15)) u_dut4k (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_desc_gaddr(k_gaddr), .i_desc_laddr(32'h0000_0000), .i_desc_len(k_len),
        .i_desc_dir(1'b0), .i_desc_vld(k_vld), .o_desc_rdy(k_rdy),
        .o_bm_global_addr(k_bm_g), .o_bm_local_addr(k_bm_l), .o_bm_length(k_bm_len),
        .o_bm_tag(k_bm_tag), .o_bm_trans_type(k_bm_type), .o_bm_req(k_req),
        .i_bm_ack(k_ack), .i_bm_op_tag(16'h0000), .i_bm_op_done(k_op_done),
        .o_busy(k_busy), .o_done(k_done), .o_err(k_err)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("req_wait", req, 1);
    endtask

    task automatic give_desc(input logic [63:0] g, input logic [31:0] l, input logic [15:0] n, input logic d);
        gaddr = g; laddr = l; len = n; dir = d; vld = 1'b1;
        step();
        vld = 1'b0;
    endtask

    task automatic do_req(input logic [63:0] g, input logic [31:0] l, input logic [11:0] n,
                          input logic [7:0] tag, input logic [1:0] typ, input int hold);
        wait_req();
        for (int h = 0; h < hold; h++) begin
            step();
            chk("hold_req", req, 1);
            chk("hold_gaddr", bm_g, g);
        end
        chk("req_gaddr", bm_g, g);
        chk("req_laddr", bm_l, l);
        chk("req_len", bm_len, n);
        chk("req_tag", bm_tag, {8'h00, tag});
        chk("req_type", bm_type, typ);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("req_gap", req, 0);
    endtask

    task automatic finish_desc(input int n_done);
        int n = 0;
        op_done = 1'b1;
        repeat (n_done) step();
        op_done = 1'b0;
        while (done !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_rdy_low", rdy, 0);
        step();
        chk("done_clear", done, 0);
        chk("rdy_after_done", rdy, 1);
    endtask

    initial begin
        // Reset state.
        repeat (2) step();
        chk("rst_req", req, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_rdy", rdy, 0);
        chk("rst_gaddr", bm_g, 0);
        chk("rst_len", bm_len, 0);
        chk("rst_tag", bm_tag, 0);
        rst_n = 1'b1;
        step();
        chk("rdy_after_rst", rdy, 1);
        chk("k_rdy_after_rst", k_rdy, 1);

        // 4096-byte single request encodes length as 0.
        k_gaddr = 64'h2000; k_len = 16'd4096; k_vld = 1'b1;
        step();
        k_vld = 1'b0;
        chk("k_req", k_req, 1);
        chk("k_len", k_bm_len, 12'd0);
        chk("k_gaddr", k_bm_g, 64'h2000);
        k_ack = 1'b1;
        step();
        k_ack = 1'b0;
        chk("k_req_drop", k_req, 0);
        chk("k_busy", k_busy, 1);
        k_op_done = 1'b1;
        step();
        k_op_done = 1'b0;
        step();
        chk("k_done", k_done, 1);

        // 1024 bytes at 0x1000: two 512-byte requests with request asserted right after acceptance.
        give_desc(64'h1000, 32'h0, 16'd1024, 1'b0);
        chk("acc_req", req, 1);
        chk("acc_busy", busy, 1);
        chk("acc_rdy", rdy, 0);
        do_req(64'h1000, 32'h000, 12'd512, 8'd0, 2'b00, 0);
        do_req(64'h1200, 32'h200, 12'd512, 8'd1, 2'b00, 0);
        finish_desc(2);
        chk("err_clean1", err, 0);

        // 100 bytes at 0x0FF0: split at the 4 KB boundary, local-to-global.
        give_desc(64'h0FF0, 32'h100, 16'd100, 1'b1);
        do_req(64'h0FF0, 32'h100, 12'd16, 8'd2, 2'b01, 0);
        do_req(64'h1000, 32'h110, 12'd84, 8'd3, 2'b01, 0);
        finish_desc(2);

        // 4096 bytes with MAX_OUTST 2: throttle after two ACKs, resume on one OP_DONE.
        give_desc(64'h4000, 32'h0, 16'd4096, 1'b0);
        do_req(64'h4000, 32'h000, 12'd512, 8'd4, 2'b00, 0);
        do_req(64'h4200, 32'h200, 12'd512, 8'd5, 2'b00, 0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("throttle_req", req, 0);
        end
        op_done = 1'b1;
        step();
        op_done = 1'b0;
        chk("resume_req", req, 1);
        for (int j = 2; j < 8; j++) begin
            do_req(64'h4000 + 64'(j * 512), 32'(j * 512), 12'd512, 8'(4 + j), 2'b00, (j == 2) ? 2 : 0);
            if (j < 7) begin
                op_done = 1'b1;
                step();
                op_done = 1'b0;
            end
        end
        finish_desc(2);

        // Simultaneous ACK and OP_DONE with one outstanding leaves the count at one.
        give_desc(64'h8000, 32'h40, 16'd1024, 1'b0);
        do_req(64'h8000, 32'h040, 12'd512, 8'd12, 2'b00, 0);
        wait_req();
        chk("sim_gaddr", bm_g, 64'h8200);
        chk("sim_tag", bm_tag, 16'd13);
        ack = 1'b1; op_done = 1'b1;
        step();
        ack = 1'b0; op_done = 1'b0;
        finish_desc(1);
        chk("err_clean2", err, 0);

        // Lone OP_DONE in IDLE sets sticky ERR.
        op_done = 1'b1;
        step();
        op_done = 1'b0;
        chk("err_set", err, 1);
        repeat (2) step();
        chk("err_sticky", err, 1);

        // Zero-length descriptor: accepted, no request, DONE next cycle.
        give_desc(64'h3000, 32'h0, 16'd0, 1'b0);
        chk("len0_done", done, 1);
        chk("len0_req", req, 0);
        chk("len0_busy", busy, 0);
        step();
        chk("len0_done_clr", done, 0);
        chk("len0_rdy", rdy, 1);

        // Reset during ISSUE drops BM_REQ asynchronously; stale OP_DONE then flags ERR.
        give_desc(64'h100, 32'h0, 16'd64, 1'b0);
        wait_req();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req", req, 0);
        chk("arst_busy", busy, 0);
        chk("arst_rdy", rdy, 0);
        chk("arst_err", err, 0);
        chk("arst_gaddr", bm_g, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("arst_rdy_after", rdy, 1);
        op_done = 1'b1;
        step();
        op_done = 1'b0;
        chk("stale_opdone_err", err, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
